// File: rtl/uart_tx_stream.sv
// Ready/valid byte stream to asynchronous serial line: start bit, data LSB first,
// optional parity bit, one or two stop bits. Word is latched on accept.
module uart_tx_stream #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              txd,
    output logic              busy
);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_stream: DATA_W must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_stream: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_stream: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_stream: STOP_BITS must be 1 or 2");
    end

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [2:0] ST_AFTER_DATA = (PARITY != 0) ? ST_PARITY : ST_STOP;

    logic [2:0]        state;
    logic [CW-1:0]     clk_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              par_bit;
    logic              par_calc;
    logic              accept;
    logic              bit_end;

    // Without parity the "parity" bit is 1, so the data->stop step can load it unconditionally.
    always_comb begin
        par_calc = 1'b1;
        if (PARITY == 2)      par_calc = ^s_data;
        else if (PARITY == 1) par_calc = ~^s_data;
    end

    assign s_ready = (state == ST_IDLE) && !nrst;
    assign busy    = (state != ST_IDLE);
    assign accept  = s_valid && s_ready;
    assign bit_end = (clk_cnt == CLK_LAST);

    always_ff @(posedge clk) begin
        if (nrst) begin
            state     <= ST_IDLE;
            txd       <= 1'b1;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shift_reg <= s_data;
                        par_bit   <= par_calc;
                        state     <= ST_START;
                        txd       <= 1'b0;
                        clk_cnt   <= '0;
                        bit_cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        clk_cnt   <= '0;
                        state     <= ST_DATA;
                        txd       <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= ST_AFTER_DATA;
                            txd     <= par_bit;
                        end else begin
                            bit_cnt   <= bit_cnt + BW'(1);
                            txd       <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        state   <= ST_STOP;
                        txd     <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    txd <= 1'b1;
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    txd     <= 1'b1;
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Runs several uart_tx_stream configurations side by side against a frame-level model:
// each accepted word becomes a bit list, and txd is that list indexed by cycle / CLKS_PER_BIT.
module tb_uart_tx_stream;

    localparam int NCFG = 5;
    localparam int DW_T   [NCFG] = '{8, 8, 8, 8, 5};
    localparam int CPB_T  [NCFG] = '{4, 4, 4, 4, 3};
    localparam int PAR_T  [NCFG] = '{0, 2, 1, 0, 1};
    localparam int SB_T   [NCFG] = '{1, 1, 1, 2, 2};
    localparam int BYTE_T [NCFG] = '{'hA5, 'h07, 'h07, 'h3C, 'h16};
    localparam int FLEN_T [NCFG] = '{40, 44, 44, 44, 27};
    // Hand-derived serial bit sequences, bit 0 = start bit
    localparam logic [15:0] LIT_T [NCFG] = '{
        16'b1101001010, 16'b11000001110, 16'b10000001110,
        16'b11001111000, 16'b110101100};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int ndone    = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic mark_done();
        ndone++;
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int DW   = DW_T[g];
        localparam int CPB  = CPB_T[g];
        localparam int PAR  = PAR_T[g];
        localparam int SB   = SB_T[g];
        localparam int NBIT = 1 + DW + ((PAR != 0) ? 1 : 0) + SB;
        localparam int FLEN = FLEN_T[g];

        logic          nrst    = 1'b1;
        logic [DW-1:0] s_data  = '0;
        logic          s_valid = 1'b0;
        logic          s_ready;
        logic          txd;
        logic          busy;

        uart_tx_stream #(
            .DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY(PAR), .STOP_BITS(SB)
        ) u_dut (
            .clk(clk), .nrst(nrst), .s_data(s_data), .s_valid(s_valid),
            .s_ready(s_ready), .txd(txd), .busy(busy)
        );

        // Model: pos = cycles since accept (-1 when idle), fb = the frame's bits
        int   pos = -1;
        logic fb [16];

        always @(posedge clk) begin
            if (nrst) begin
                pos = -1;
            end else if (pos < 0) begin
                if (s_valid) begin
                    fb[0] = 1'b0;
                    for (int i = 0; i < DW; i++) fb[1 + i] = s_data[i];
                    for (int i = 1 + DW; i < NBIT; i++) fb[i] = 1'b1;
                    if (PAR == 2) fb[1 + DW] = ^s_data;
                    else if (PAR == 1) fb[1 + DW] = ~^s_data;
                    pos = 0;
                end
            end else begin
                pos++;
                if (pos == NBIT * CPB) pos = -1;
            end
        end

        always @(negedge clk) begin
            chk($sformatf("cfg%0d txd pos=%0d", g, pos), int'(txd), (pos < 0) ? 1 : int'(fb[pos / CPB]));
            chk($sformatf("cfg%0d busy pos=%0d", g, pos), int'(busy), int'(pos >= 0));
            chk($sformatf("cfg%0d s_ready pos=%0d", g, pos), int'(s_ready), int'(pos < 0 && !nrst));
        end

        initial begin
            int t, mism, nbusy, nrdy, f1, f2, bad;
            logic prev;
            logic [15:0] lit;
            lit = LIT_T[g];

            // Reset state
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk($sformatf("cfg%0d reset txd", g), int'(txd), 1);
            chk($sformatf("cfg%0d reset busy", g), int'(busy), 0);
            chk($sformatf("cfg%0d reset s_ready", g), int'(s_ready), 0);
            @(posedge clk); #2;
            nrst = 1'b0;
            @(posedge clk); #2;

            // Single frame against a literal bit pattern and length
            s_valid = 1'b1;
            s_data  = DW'(BYTE_T[g]);
            @(posedge clk); #2;
            s_valid = 1'b0;
            s_data  = ~s_data;
            mism = 0; nbusy = 0; nrdy = 0;
            for (int k = 0; k < FLEN + 4; k++) begin
                @(negedge clk);
                if (k < FLEN && txd != lit[k / CPB]) mism++;
                if (busy) nbusy++;
                if (!s_ready) nrdy++;
            end
            chk($sformatf("cfg%0d frame pattern mismatches", g), mism, 0);
            chk($sformatf("cfg%0d busy cycles", g), nbusy, FLEN);
            chk($sformatf("cfg%0d s_ready low cycles", g), nrdy, FLEN);
            @(posedge clk); #2;

            // Back-to-back: 0x00 then all ones, s_valid held
            prev = 1'b1; f1 = -1; f2 = -1;
            s_valid = 1'b1;
            s_data  = '0;
            for (int k = 0; k < 2 * FLEN + 20; k++) begin
                @(negedge clk);
                if (prev && !txd) begin
                    if (f1 < 0) begin
                        f1 = k;
                        s_data = '1;
                    end else if (f2 < 0) begin
                        f2 = k;
                        s_valid = 1'b0;
                    end
                end
                prev = txd;
            end
            s_valid = 1'b0;
            chk($sformatf("cfg%0d back-to-back start spacing", g), f2 - f1, FLEN + 1);
            @(posedge clk); #2;
            t = 0;
            while (pos >= 0 && t < 500) begin @(posedge clk); #2; t++; end
            chk($sformatf("cfg%0d idle wait b2b", g), int'(pos < 0), 1);

            // Reset mid-frame, then a clean frame
            s_valid = 1'b1;
            s_data  = DW'('h55);
            @(posedge clk); #2;
            s_valid = 1'b0;
            repeat (9) @(posedge clk);
            #2 nrst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("cfg%0d abort txd", g), int'(txd), 1);
            chk($sformatf("cfg%0d abort busy", g), int'(busy), 0);
            chk($sformatf("cfg%0d abort s_ready", g), int'(s_ready), 0);
            repeat (2) @(posedge clk);
            #2 nrst = 1'b0;
            @(negedge clk);
            chk($sformatf("cfg%0d s_ready after release", g), int'(s_ready), 1);
            @(posedge clk); #2;
            s_valid = 1'b1;
            s_data  = DW'('h0F);
            @(posedge clk); #2;
            s_valid = 1'b0;
            t = 0;
            while (pos >= 0 && t < 500) begin @(posedge clk); #2; t++; end
            chk($sformatf("cfg%0d idle wait post-reset", g), int'(pos < 0), 1);

            // Idle hold with toggling data
            bad = 0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (txd != 1'b1 || busy != 1'b0 || s_ready != 1'b1) bad++;
                s_data = DW'($urandom);
            end
            chk($sformatf("cfg%0d idle hold violations", g), bad, 0);
            @(posedge clk); #2;

            // Random traffic with occasional resets
            for (int i = 0; i < 400; i++) begin
                @(posedge clk); #2;
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = DW'($urandom);
                nrst    = ($urandom_range(0, 149) == 0);
            end
            @(posedge clk); #2;
            nrst    = 1'b0;
            s_valid = 1'b0;
            t = 0;
            while (pos >= 0 && t < 500) begin @(posedge clk); #2; t++; end
            chk($sformatf("cfg%0d idle wait final", g), int'(pos < 0), 1);
            mark_done();
        end
    end

    initial begin
        for (int t = 0; t < 30000 && ndone < NCFG; t++) @(posedge clk);
        #3;
        chk("all configs done", ndone, NCFG);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
- Serialises bytes taken from a ready/valid stream onto an asynchronous serial line: start bit, data LSB first, optional parity bit, stop bit(s).
- Sits directly downstream of the team's fifo block. Its s_* port connects to the fifo's output-side data/valid/ready. Backpressure throttles the fifo while a frame is on the wire.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; 1 or 2.
- Any illegal parameter value is an elaboration-time error.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-high
- s_data  in  DATA_W  word to transmit; sampled only on an accept
- s_valid  in  1  upstream has a word
- s_ready  out  1  block can accept a word this cycle
- txd  out  1  serial line, registered; idle level 1
- busy  out  1  frame in progress (state != IDLE)

Behaviour:
- Reset (nrst=1 at a clk edge):
  - state <= IDLE, txd <= 1, all counters <= 0.
  - s_ready = 0 for as long as nrst is asserted; busy = 0.
- s_ready = (state == IDLE) and not nrst. It is combinational, with no dependency on s_valid.
- Accept: s_valid & s_ready at an edge.
  - shift register <= s_data.
  - parity bit computed from s_data: XOR of the data bits for even; inverted XOR for odd.
  - state <= START, txd <= 0 at that same edge.
- States: IDLE -> START -> DATA -> (PARITY if PARITY != 0) -> STOP -> IDLE.
- Each serial bit holds txd for exactly CLKS_PER_BIT cycles, timed by clk_cnt counting 0..CLKS_PER_BIT-1.
- DATA:
  - bit_cnt counts 0..DATA_W-1.
  - txd = shift_reg[0]; the shift register shifts right at each bit boundary.
- PARITY: txd = parity bit for one bit period.
- STOP:
  - txd = 1 for STOP_BITS bit periods.
  - At the final cycle edge: state <= IDLE, txd stays 1.
- Frame length: F = (1 + DATA_W + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles, measured from the accept edge to the IDLE edge.
- Back-to-back frames:
  - s_ready rises in the cycle after the IDLE edge.
  - With s_valid held high, the next accept occurs at the next edge.
  - Start-bit falling edges are therefore F+1 cycles apart. The single extra idle clk is intentional.
- s_valid low in IDLE: txd stays 1 and no state change. s_data is ignored when not accepting.
- Upstream changing s_data mid-frame has no effect; the word is latched at accept.
- Reset mid-frame: the frame is aborted. txd = 1 from the next edge, the word is lost and is not retried, and s_ready is re-asserted the first cycle after nrst deasserts.
- busy is high from the accept edge through the final stop cycle.
- Counter widths:
  - clk_cnt = $clog2(CLKS_PER_BIT) bits.
  - bit_cnt = $clog2(DATA_W) bits, minimum 1.
  - No wrap-around is permitted inside a frame.

Test Plan:
- Basic frame: DATA_W=8, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1; send 0xA5.
  - txd = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles.
  - s_ready low for 40 cycles; busy high for 40 cycles.
- Parity: with CLKS_PER_BIT=4, send 0x07.
  - PARITY=2: parity bit = 1.
  - PARITY=1: parity bit = 0.
  - In both cases F = 44 cycles.
- Back-to-back: s_valid held high with 0x00 then 0xFF, no parity, 1 stop bit.
  - Second start bit falls exactly 41 cycles after the first.
  - No glitch on txd between the frames.
- Two stop bits: STOP_BITS=2; send 0x3C.
  - txd stays high for 8 cycles after the data bits; F = 44.
  - Second accept no earlier than cycle 45.
- Reset mid-frame: assert nrst 10 cycles into 0x55.
  - txd = 1 and busy = 0 at the next edge; s_ready = 0 while reset is held.
  - After release, send 0x0F: its frame is correct and nothing from 0x55 reappears.
- Idle hold: s_valid = 0 for 100 cycles with s_data toggling.
  - txd constantly 1, busy = 0, s_ready = 1.
